spi_receiver: RTL and testbench
===============================

# spi_receiver

SPI slave-side deserializer that consumes the ss/sclk/mosi bundle produced by `spi_stimulus` (or an external master) and delivers each complete word as a parallel value with a one-cycle valid strobe. It oversamples all SPI lines with the system clock and rejects transfers whose sampling-edge count differs from `bitcount`, whether aborted early or overrun. It sits directly downstream of the SPI stimulus/master stage, feeding register-file or FIFO logic.

## Interface
- `bitcount`, 8: bits per transfer, ≥2.
- `ss_polarity`, 0: active level of ss (0 = active low).
- `sclk_polarity`, 0: idle level of sclk; the sampling edge is the idle→active transition (rising for 0, falling for 1).
- `msb_first`, 1: 1 = first received bit lands in `data[bitcount-1]`; 0 = in `data[0]`.
- `clock` input 1: system clock; everything is on its rising edge.
- `reset` input 1: synchronous, active-high reset.
- `ss` input 1: slave select; asynchronous to `clock`.
- `sclk` input 1: SPI clock; asynchronous to `clock`.
- `mosi` input 1: serial data; asynchronous to `clock`.
- `data` output bitcount: last correctly received word; reset 0.
- `data_valid` output 1: one-cycle pulse when `data` updates; reset 0.
- `error` output 1: one-cycle pulse when a transfer ends with the wrong bit count; reset 0.
- `busy` output 1: high while in ACTIVE; reset 0.

## Operation
- `ss`, `sclk`, `mosi` each pass through two synchronizer flops (s1, s2) plus a history flop (s3). These flops are not reset. An edge is detected when s2 ≠ s3.
- State machine (state, bit counter, shift register, and outputs are reset):
  - WAIT_IDLE (reset state): goes to IDLE once s2 and s3 of ss are both inactive. This stops a transfer already in progress at reset release from being captured.
  - IDLE: on an ss inactive→active edge, clear the counter and shift register and go to ACTIVE.
  - ACTIVE: on each sclk sampling edge, shift in s2 of mosi and increment the counter. The counter saturates at `bitcount+1`, and shifting stops once the count exceeds `bitcount`. On an ss active→inactive edge, go to IDLE:
    - count == bitcount: load `data` from the shift register and pulse `data_valid`.
    - otherwise: pulse `error`; `data` is unchanged.
- A sclk sampling edge and an ss deassert edge detected in the same cycle: the bit is counted and shifted first, then the end-of-transfer check uses the updated count.
- An ss assert edge detected in the same cycle that the FSM enters IDLE is not missed. The FSM starts the new transfer on the following cycle using the still-pending s2/s3 state, or the bench guarantees an inactive gap of at least 2 cycles.
- sclk edges are ignored outside ACTIVE.
- `reset` in ACTIVE: return to WAIT_IDLE with no `data_valid` or `error`. `data` is cleared to 0.
- `data_valid` and `error` are never high in the same cycle.

## Timing
- Input sampled at rising edge E0: it is visible in s2 after E1 and detected during the E1–E2 cycle. The resulting register update happens at E2.
- `data_valid`/`error` are high for exactly the cycle after E2. Latency from the first `clock` edge sampling ss inactive is 2 cycles.
- Reliable capture requires each sclk high and low phase, and the ss inactive gap, to be ≥2 `clock` periods. mosi must be stable for ≥2 periods around the sampling edge.
- `busy` rises at E2 of the ss assert edge and falls at E2 of the ss deassert edge.
- Exiting reset with ss inactive: IDLE is reached 1 cycle after `reset` falls, provided s2 and s3 already hold the inactive level.

## Test plan
- All four (`ss_polarity`, `sclk_polarity`) combinations, `bitcount`=4, MSB-first word 4'b1011 driven by `spi_stimulus` → `data`=4'hB, one `data_valid` pulse 2 cycles after ss deasserts, `error` stays 0.
- Abort after 2 sampling edges (stimulus `abort`) → `error` pulses once, `data` keeps 4'hB, no `data_valid`.
- Six sampling edges with `bitcount`=4 → `error` pulses and `data` is unchanged. The next normal 4'b0110 transfer → `data`=4'h6 with `data_valid`.
- `msb_first`=0, received sequence 1,0,0,0 → `data`=4'h1.
- `reset` asserted mid-transfer while ss stays active, then released → no strobes; after ss goes inactive and a full transfer completes, `data_valid` pulses with the correct word.
- The 4th sampling edge lands in the same cycle as ss deassert detection → counted; `data_valid` pulses with all 4 bits.

Source files
------------

// File: rtl/spi_receiver_if.sv
// Signal bundle between an SPI master and spi_receiver: the three serial lines
// plus the receiver's parallel word, strobes and busy flag.
interface spi_receiver_if #(
  parameter int bitcount = 8
);
  logic                ss;
  logic                sclk;
  logic                mosi;
  logic [bitcount-1:0] data;
  logic                data_valid;
  logic                error;
  logic                busy;

  modport master (
    output ss,
    output sclk,
    output mosi,
    input  data,
    input  data_valid,
    input  error,
    input  busy
  );

  modport slave (
    input  ss,
    input  sclk,
    input  mosi,
    output data,
    output data_valid,
    output error,
    output busy
  );
endinterface

// File: rtl/spi_receiver.sv
// Oversampling SPI slave deserializer: delivers each complete bitcount-bit word
// with a one-cycle valid strobe and flags transfers with the wrong edge count.
module spi_receiver #(
  parameter int bitcount      = 8,
  parameter bit ss_polarity   = 1'b0,
  parameter bit sclk_polarity = 1'b0,
  parameter bit msb_first     = 1'b1
) (
  input  logic    clock,
  input  logic    reset,
  spi_receiver_if.slave spi
);

  localparam int CW = $clog2(bitcount + 2);

  typedef enum logic [1:0] {
    WAIT_IDLE = 2'd0,
    IDLE      = 2'd1,
    ACTIVE    = 2'd2
  } state_t;

  // Lines in bit order: 0 = ss, 1 = sclk, 2 = mosi
  logic [2:0] line_in;
  logic [2:0] s2_vec;
  logic [2:0] s3_vec;

  assign line_in = {spi.mosi, spi.sclk, spi.ss};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_sync
      logic s1_reg;
      logic s2_reg;
      logic s3_reg;

      always_ff @(posedge clock) begin
        s1_reg <= line_in[gi];
        s2_reg <= s1_reg;
        s3_reg <= s2_reg;
      end

      assign s2_vec[gi] = s2_reg;
      assign s3_vec[gi] = s3_reg;
    end
  endgenerate

  logic ss_act_s2;
  logic ss_act_s3;
  logic ss_assert;
  logic ss_deassert;
  logic sclk_sample;
  logic mosi_s2;

  assign ss_act_s2   = (s2_vec[0] == ss_polarity);
  assign ss_act_s3   = (s3_vec[0] == ss_polarity);
  assign ss_assert   = ss_act_s2 & ~ss_act_s3;
  assign ss_deassert = ~ss_act_s2 & ss_act_s3;
  // Sampling edge is the idle-to-active transition of sclk
  assign sclk_sample = (s3_vec[1] == sclk_polarity) && (s2_vec[1] != sclk_polarity);
  assign mosi_s2     = s2_vec[2];

  state_t              state_reg,      state_next;
  logic [CW-1:0]       count_reg,      count_next;
  logic [bitcount-1:0] shift_reg,      shift_next;
  logic [bitcount-1:0] data_reg,       data_next;
  logic                data_valid_reg, data_valid_next;
  logic                error_reg,      error_next;
  logic [bitcount-1:0] shifted_word;

  generate
    if (msb_first) begin : g_msb
      assign shifted_word = {shift_reg[bitcount-2:0], mosi_s2};
    end else begin : g_lsb
      assign shifted_word = {mosi_s2, shift_reg[bitcount-1:1]};
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg      <= WAIT_IDLE;
      count_reg      <= '0;
      shift_reg      <= '0;
      data_reg       <= '0;
      data_valid_reg <= 1'b0;
      error_reg      <= 1'b0;
    end else begin
      state_reg      <= state_next;
      count_reg      <= count_next;
      shift_reg      <= shift_next;
      data_reg       <= data_next;
      data_valid_reg <= data_valid_next;
      error_reg      <= error_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    count_next      = count_reg;
    shift_next      = shift_reg;
    data_next       = data_reg;
    data_valid_next = 1'b0;
    error_next      = 1'b0;

    case (state_reg)
      WAIT_IDLE: begin
        // A transfer already running when reset lifts must be skipped entirely
        if (!ss_act_s2 && !ss_act_s3) begin
          state_next = IDLE;
        end
      end

      IDLE: begin
        if (ss_assert) begin
          count_next = '0;
          shift_next = '0;
          state_next = ACTIVE;
        end
      end

      ACTIVE: begin
        if (sclk_sample) begin
          if (count_reg < CW'(bitcount)) begin
            shift_next = shifted_word;
          end
          if (count_reg < CW'(bitcount + 1)) begin
            count_next = count_reg + 1'b1;
          end
        end
        // End check sees a bit sampled in this same cycle
        if (ss_deassert) begin
          state_next = IDLE;
          if (count_next == CW'(bitcount)) begin
            data_next       = shift_next;
            data_valid_next = 1'b1;
          end else begin
            error_next = 1'b1;
          end
        end
      end

      default: begin
        state_next = WAIT_IDLE;
      end
    endcase
  end

  assign spi.data       = data_reg;
  assign spi.data_valid = data_valid_reg;
  assign spi.error      = error_reg;
  assign spi.busy       = (state_reg == ACTIVE);

endmodule

// File: tb/tb_spi_receiver.sv
// Randomized bench for spi_receiver: five instances (all ss/sclk polarities plus
// LSB-first) share one logical SPI stream and are checked every cycle against a model.
module tb_spi_receiver;

  localparam int BC = 4;
  localparam int EV_BUSY1 = 0;
  localparam int EV_BUSY0 = 1;
  localparam int EV_VALID = 2;
  localparam int EV_ERROR = 3;
  localparam int EV_RESET = 4;

  typedef struct {
    int            at;
    int            kind;
    logic [BC-1:0] wm;
    logic [BC-1:0] wl;
  } ev_t;

  logic clock = 1'b0;
  logic reset;
  logic ss_l, sclk_l, mosi_l;

  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int exp_valid_total = 0;
  int valid_seen = 0;

  ev_t  evq[$];
  logic bits_q[$];
  bit   in_xfer = 1'b0;

  logic [BC-1:0] exp_dm, exp_dl;
  logic          exp_v, exp_e, exp_b;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  spi_receiver_if #(.bitcount(BC)) if00 ();
  spi_receiver_if #(.bitcount(BC)) if01 ();
  spi_receiver_if #(.bitcount(BC)) if10 ();
  spi_receiver_if #(.bitcount(BC)) if11 ();
  spi_receiver_if #(.bitcount(BC)) iflsb ();

  // Logical levels: ss_l=1 means selected, sclk_l=1 means active phase
  assign if00.ss  = ~ss_l;   assign if00.sclk  = sclk_l;   assign if00.mosi  = mosi_l;
  assign if01.ss  = ~ss_l;   assign if01.sclk  = ~sclk_l;  assign if01.mosi  = mosi_l;
  assign if10.ss  = ss_l;    assign if10.sclk  = sclk_l;   assign if10.mosi  = mosi_l;
  assign if11.ss  = ss_l;    assign if11.sclk  = ~sclk_l;  assign if11.mosi  = mosi_l;
  assign iflsb.ss = ~ss_l;   assign iflsb.sclk = sclk_l;   assign iflsb.mosi = mosi_l;

  spi_receiver #(.bitcount(BC), .ss_polarity(1'b0), .sclk_polarity(1'b0), .msb_first(1'b1))
    u00 (.clock(clock), .reset(reset), .spi(if00));
  spi_receiver #(.bitcount(BC), .ss_polarity(1'b0), .sclk_polarity(1'b1), .msb_first(1'b1))
    u01 (.clock(clock), .reset(reset), .spi(if01));
  spi_receiver #(.bitcount(BC), .ss_polarity(1'b1), .sclk_polarity(1'b0), .msb_first(1'b1))
    u10 (.clock(clock), .reset(reset), .spi(if10));
  spi_receiver #(.bitcount(BC), .ss_polarity(1'b1), .sclk_polarity(1'b1), .msb_first(1'b1))
    u11 (.clock(clock), .reset(reset), .spi(if11));
  spi_receiver #(.bitcount(BC), .ss_polarity(1'b0), .sclk_polarity(1'b0), .msb_first(1'b0))
    ulsb (.clock(clock), .reset(reset), .spi(iflsb));

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  function automatic int rph();
    return $urandom_range(2, 4);
  endfunction

  // Expected output events, ordered by the cycle at which they become visible
  task automatic push_ev(input int delay, input int kind, input logic [BC-1:0] wm, input logic [BC-1:0] wl);
    ev_t e;
    int  idx;
    e.at = cyc + delay; e.kind = kind; e.wm = wm; e.wl = wl;
    idx = evq.size();
    for (int i = 0; i < evq.size(); i++) begin
      if (evq[i].at > e.at) begin
        idx = i;
        break;
      end
    end
    evq.insert(idx, e);
  endtask

  task automatic ss_on();
    ss_l = 1'b1;
    in_xfer = 1'b1;
    bits_q.delete();
    push_ev(3, EV_BUSY1, '0, '0);
  endtask

  task automatic sclk_rise();
    sclk_l = 1'b1;
    if (in_xfer) bits_q.push_back(mosi_l);
  endtask

  task automatic ss_off();
    logic [BC-1:0] wm, wl;
    ss_l = 1'b0;
    if (in_xfer) begin
      wm = '0;
      wl = '0;
      if (bits_q.size() == BC) begin
        for (int i = 0; i < BC; i++) begin
          wm[BC-1-i] = bits_q[i];
          wl[i]      = bits_q[i];
        end
        push_ev(3, EV_VALID, wm, wl);
      end else begin
        push_ev(3, EV_ERROR, wm, wl);
      end
      push_ev(3, EV_BUSY0, '0, '0);
    end
    in_xfer = 1'b0;
  endtask

  // pattern[i] is the i-th bit put on the wire
  task automatic xfer(input int n, input logic [7:0] pattern, input bit same_end);
    ss_on();
    tick(rph());
    for (int i = 0; i < n; i++) begin
      mosi_l = pattern[i];
      tick(rph());
      if (same_end && i == n - 1) begin
        sclk_rise();
        ss_off();
        tick(rph());
        sclk_l = 1'b0;
      end else begin
        sclk_rise();
        tick(rph());
        sclk_l = 1'b0;
        tick(rph());
      end
    end
    if (!(same_end && n > 0)) ss_off();
    tick(6 + $urandom_range(0, 3));
  endtask

  task automatic xfer_word(input logic [BC-1:0] word, input bit same_end);
    logic [7:0] p;
    p = '0;
    for (int i = 0; i < BC; i++) p[i] = word[BC-1-i];
    xfer(BC, p, same_end);
  endtask

  task automatic lit(input string nm, input logic [BC-1:0] got, input logic [BC-1:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", nm, got, want);
    end
  endtask

  task automatic chk(input string nm, input logic [BC-1:0] d, input logic v, input logic e,
                     input logic b, input logic [BC-1:0] xd);
    checks++;
    if (d !== xd || v !== exp_v || e !== exp_e || b !== exp_b) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s cyc=%0d got data=%h valid=%b error=%b busy=%b expected data=%h valid=%b error=%b busy=%b",
                 nm, cyc, d, v, e, b, xd, exp_v, exp_e, exp_b);
    end
  endtask

  // Per-cycle compare against the event model
  initial begin
    ev_t e;
    exp_dm = '0; exp_dl = '0; exp_v = 1'b0; exp_e = 1'b0; exp_b = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      exp_v = 1'b0;
      exp_e = 1'b0;
      while (evq.size() > 0 && evq[0].at <= cyc) begin
        e = evq.pop_front();
        case (e.kind)
          EV_BUSY1: exp_b = 1'b1;
          EV_BUSY0: exp_b = 1'b0;
          EV_VALID: begin exp_v = 1'b1; exp_dm = e.wm; exp_dl = e.wl; exp_valid_total++; end
          EV_ERROR: exp_e = 1'b1;
          default:  begin exp_dm = '0; exp_dl = '0; exp_b = 1'b0; exp_v = 1'b0; exp_e = 1'b0; end
        endcase
      end
      if (if00.data_valid === 1'b1) valid_seen++;
      chk("p00", if00.data, if00.data_valid, if00.error, if00.busy, exp_dm);
      chk("p01", if01.data, if01.data_valid, if01.error, if01.busy, exp_dm);
      chk("p10", if10.data, if10.data_valid, if10.error, if10.busy, exp_dm);
      chk("p11", if11.data, if11.data_valid, if11.error, if11.busy, exp_dm);
      chk("lsb", iflsb.data, iflsb.data_valid, iflsb.error, iflsb.busy, exp_dl);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pat;
    int n;
    reset = 1'b1; ss_l = 1'b0; sclk_l = 1'b0; mosi_l = 1'b0;
    tick(6);
    lit("reset_data", if00.data, 4'h0);
    reset = 1'b0;
    tick(4);

    xfer_word(4'b1011, 1'b0);
    lit("model_word_b", exp_dm, 4'hB);
    lit("word_b_p00", if00.data, 4'hB);
    lit("word_b_p01", if01.data, 4'hB);
    lit("word_b_p10", if10.data, 4'hB);
    lit("word_b_p11", if11.data, 4'hB);
    lit("word_b_lsb", iflsb.data, 4'hD);

    xfer(2, 8'b0000_0011, 1'b0);
    lit("abort_keeps_b", if00.data, 4'hB);
    xfer(6, 8'b0010_1101, 1'b0);
    lit("overrun_keeps_b", if11.data, 4'hB);

    xfer_word(4'b0110, 1'b0);
    lit("word_6_p00", if00.data, 4'h6);
    lit("word_6_lsb", iflsb.data, 4'h6);

    xfer(4, 8'b0000_0001, 1'b0);
    lit("seq1000_lsb", iflsb.data, 4'h1);
    lit("seq1000_msb", if00.data, 4'h8);

    xfer_word(4'b1001, 1'b1);
    lit("same_cycle_end", if10.data, 4'h9);

    // Reset while ss stays selected: that transfer must vanish silently
    ss_on();
    tick(3);
    for (int i = 0; i < 2; i++) begin
      mosi_l = 1'($urandom_range(0, 1)); tick(2); sclk_rise(); tick(2); sclk_l = 1'b0; tick(2);
    end
    reset = 1'b1;
    push_ev(1, EV_RESET, '0, '0);
    in_xfer = 1'b0;
    tick(3);
    reset = 1'b0;
    tick(2);
    for (int i = 0; i < 3; i++) begin
      mosi_l = 1'($urandom_range(0, 1)); tick(2); sclk_rise(); tick(2); sclk_l = 1'b0; tick(2);
    end
    ss_off();
    tick(8);
    lit("after_reset_data", if00.data, 4'h0);
    xfer_word(4'b0101, 1'b0);
    lit("post_reset_word", if00.data, 4'h5);

    for (int t = 0; t < 150; t++) begin
      n = ($urandom_range(0, 9) < 6) ? BC : $urandom_range(0, 6);
      pat = 8'($urandom);
      xfer(n, pat, (n > 0) && ($urandom_range(0, 3) == 0));
    end

    tick(8);
    checks++;
    if (valid_seen != exp_valid_total) begin
      failures++;
      $display("FAIL valid_pulse_count got=%0d expected=%0d", valid_seen, exp_valid_total);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
